// File: rtl/mmix_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmix_mem_pkg
// Purpose  : Shared types and helpers for the MMIX memory-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mmix_mem_pkg;

   localparam int unsigned MMIX_AW = 64;
   localparam int unsigned MMIX_DW = 64;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_WYDE  = 2'd1,
      SZ_TETRA = 2'd2,
      SZ_OCTA  = 2'd3
   } datasize_t;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [MMIX_AW-1:0] addr;
      datasize_t          size;
      logic               rd;
      logic               wr;
      logic [MMIX_DW-1:0] wdata;
   } mem_req_t;

   // Winner selection: a lone requester always wins; on a conflict D wins
   // under fixed priority, otherwise the port that was not served last wins.
   function automatic logic arb_pick_d(input logic req_i,
                                       input logic req_d,
                                       input logic last_was_d,
                                       input logic fixed_prio);
      logic pick;
      if (req_i && req_d) begin
         pick = fixed_prio ? 1'b1 : ~last_was_d;
      end else begin
         pick = req_d;
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmix_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mmix_arb_watchdog
// Purpose  : BUSY-cycle counter for the MMIX arbiter. Cleared on grant,
//            counts while the arbiter is busy, flags expiry in the
//            TIMEOUT_CYCLES-th busy cycle. Built only with MMIX_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mmix_arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count value equals (busy cycles elapsed - 1), so expiry lands on the
   // TIMEOUT_CYCLES-th busy cycle itself.
   assign expired_o = run_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next count: restart on grant, advance while busy, saturate at expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mmix_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmix_mem_arbiter
// Purpose  : Shares the single MMIX memory port between instruction fetch (I)
//            and load/store (D). One transaction at a time, command registered
//            onto the memory side, done/readdata routed to the granted port.
//            Optional watchdog abort when MMIX_ARB_TIMEOUT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module mmix_mem_arbiter
   import mmix_mem_pkg::*;
#(
   parameter int FIXED_PRIO     = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   // instruction-fetch requester
   input  logic [63:0] i_address,
   input  logic [1:0]  i_datasize,
   input  logic        i_read,
   input  logic        i_write,
   input  logic [63:0] i_writedata,
   output logic [63:0] i_readdata,
   output logic        i_done,
   // load/store requester
   input  logic [63:0] d_address,
   input  logic [1:0]  d_datasize,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [63:0] d_writedata,
   output logic [63:0] d_readdata,
   output logic        d_done,
   // memory side
   output logic [63:0] mmix_address,
   output logic [1:0]  mmix_datasize,
   output logic        mmix_read,
   output logic        mmix_write,
   output logic [63:0] mmix_writedata,
   input  logic [63:0] mmix_readdata,
   input  logic        mmix_done,
   // status
   output logic        grant_d,
   output logic        busy,
   output logic        proto_err,
   output logic        timeout_err
);

   arb_state_t state_q, state_d;
   mem_req_t   cmd_q, cmd_d;
   logic       gnt_d_q, gnt_d_d;
   logic       last_was_d_q, last_was_d_d;
   logic       proto_q, proto_d;
   logic       tout_q, tout_d;

   logic       i_req, d_req;
   logic       pick_port_d;
   logic       sel_rd, sel_wr;
   mem_req_t   sel_cmd;
   logic       wd_clear;
   logic       timeout;

   assign i_req       = i_read | i_write;
   assign d_req       = d_read | d_write;
   assign pick_port_d = arb_pick_d(i_req, d_req, last_was_d_q, FIXED_PRIO != 0);
   assign sel_wr      = pick_port_d ? d_write : i_write;
   assign sel_rd      = pick_port_d ? d_read  : i_read;

   // Candidate command from the winning port; read+write collapses to a write.
   always_comb begin
      sel_cmd.addr  = pick_port_d ? d_address : i_address;
      sel_cmd.size  = datasize_t'(pick_port_d ? d_datasize : i_datasize);
      sel_cmd.rd    = sel_rd & ~sel_wr;
      sel_cmd.wr    = sel_wr;
      sel_cmd.wdata = pick_port_d ? d_writedata : i_writedata;
   end

`ifdef MMIX_ARB_TIMEOUT_EN
   logic wd_expired;

   mmix_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_i   (wd_clear),
      .run_i     (busy),
      .expired_o (wd_expired)
   );

   // A real completion in the expiry cycle takes precedence over the abort.
   assign timeout = wd_expired & ~mmix_done;
`else
   logic unused_wd;

   // Without the watchdog a transaction waits for mmix_done indefinitely.
   assign unused_wd = wd_clear ^ (TIMEOUT_CYCLES != 0);
   assign timeout   = 1'b0;
`endif

   // Next-state logic: grant and latch in IDLE, release on done/abort in BUSY.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      gnt_d_d      = gnt_d_q;
      last_was_d_d = last_was_d_q;
      proto_d      = proto_q;
      tout_d       = tout_q;
      wd_clear     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (i_req || d_req) begin
               cmd_d    = sel_cmd;
               gnt_d_d  = pick_port_d;
               proto_d  = proto_q | (sel_rd & sel_wr);
               wd_clear = 1'b1;
               state_d  = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            // Address/size/data stay put; only the strobes drop on completion.
            if (mmix_done || timeout) begin
               cmd_d.rd     = 1'b0;
               cmd_d.wr     = 1'b0;
               last_was_d_d = gnt_d_q;
               tout_d       = tout_q | timeout;
               state_d      = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State and command registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ARB_IDLE;
         cmd_q        <= '0;
         gnt_d_q      <= 1'b0;
         last_was_d_q <= 1'b1;
         proto_q      <= 1'b0;
         tout_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         gnt_d_q      <= gnt_d_d;
         last_was_d_q <= last_was_d_d;
         proto_q      <= proto_d;
         tout_q       <= tout_d;
      end
   end

   assign busy           = (state_q == ARB_BUSY);
   assign mmix_address   = cmd_q.addr;
   assign mmix_datasize  = cmd_q.size;
   assign mmix_read      = cmd_q.rd;
   assign mmix_write     = cmd_q.wr;
   assign mmix_writedata = cmd_q.wdata;
   assign grant_d        = gnt_d_q;
   assign proto_err      = proto_q;
   assign timeout_err    = tout_q;

   // Completion is routed only to the granted port and only while BUSY.
   assign i_done     = busy & ~gnt_d_q & (mmix_done | timeout);
   assign d_done     = busy &  gnt_d_q & (mmix_done | timeout);
   assign i_readdata = timeout ? '0 : mmix_readdata;
   assign d_readdata = timeout ? '0 : mmix_readdata;

endmodule
`default_nettype wire
